mod_synth_sequencer: RTL
========================

# mod_synth_sequencer

Sample-rate scheduler for the additive synth datapath. Divides the system clock down to the audio sample rate, issues one trigger plus time index per sample to the synth, and waits for its ready. It captures the resulting sound word into a small FIFO and presents it to the downstream codec/stream interface with a valid/ready handshake. It sits between the synth voice and the audio output path and reports scheduling faults through sticky flags.

## Interface

- `CLK_DIV`, 1042: clock cycles per sample period; must be ≥ 8.
- `TIMEOUT`, 256: maximum cycles spent waiting for synth ready; must be < `CLK_DIV` − 4.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.

- `i_clk`  in  1  system clock.
- `i_nrst`  in  1  reset; asynchronous, active-low.
- `i_enable`  in  1  level; sample ticks are generated only while high.
- `i_clear_errors`  in  1  one-cycle pulse; clears all sticky flags.
- `o_time`  out  64  sample index presented to the synth.
- `o_trigger`  out  1  one-cycle pulse starting a synth computation.
- `i_synth_ready`  in  1  synth result valid.
- `i_synth_sound`  in  32 signed  synth result.
- `o_sample`  out  32 signed  FIFO head.
- `o_sample_valid`  out  1  FIFO non-empty.
- `i_sample_ready`  in  1  downstream accepts the head when high with valid.
- `o_busy`  out  1  FSM is not in IDLE.
- `o_overrun`  out  1  sticky; a tick arrived while the FSM was busy.
- `o_overflow`  out  1  sticky; a sample was dropped because the FIFO was full.
- `o_timeout`  out  1  sticky; the synth failed to answer within `TIMEOUT`.

## Operation

- Divider counter is `$clog2(CLK_DIV)` bits wide. It counts 0..`CLK_DIV`−1 while `i_enable` is high. It is held at 0 while `i_enable` is low.
- A tick occurs in the cycle where the counter equals `CLK_DIV`−1.
- Tick counter is 64 bits. It increments on every tick and wraps at 2^64 to 0. It is cleared only by reset.
- FSM states and transitions:
  - IDLE: on a tick, latch the tick counter into `o_time` and go to TRIGGER.
  - TRIGGER: `o_trigger` = 1 for this cycle only; go to WAIT. `i_synth_ready` is ignored in this cycle.
  - WAIT: if `i_synth_ready`, capture `i_synth_sound` and go to STORE.
  - STORE: push the captured word into the FIFO; go to IDLE.
- A tick in any state other than IDLE sets `o_overrun`. That sample is skipped, but the tick counter still increments, so the time index skips one value.
- FIFO behaviour:
  - First-word-fall-through. `o_sample_valid` is high when the FIFO is non-empty; `o_sample` is the head entry.
  - Pop when `o_sample_valid & i_sample_ready`.
  - Push when the FIFO is full and no pop occurs in the same cycle: the word is dropped and `o_overflow` is set.
  - Full FIFO with a simultaneous pop: the push is accepted.
- `i_enable` falling mid-transaction: the current transaction completes normally and the FIFO keeps draining.
- `i_clear_errors` and a new error in the same cycle: the error wins, and the flag stays set.
- `o_time` holds its last value between triggers.

## Timing

- Reset values: `o_time` = 0, `o_trigger` = 0, `o_sample` = 0, `o_sample_valid` = 0, `o_busy` = 0, all flags 0. FSM is in IDLE, FIFO is empty, and both counters are 0.
- Reset is asynchronous: asserting `i_nrst` mid-transaction forces all of the above immediately and discards FIFO contents.
- Let T be the tick cycle:
  - T+1: `o_trigger` = 1 and `o_time` is valid.
  - T+2: first cycle of WAIT.
- Let R be the cycle in WAIT where `i_synth_ready` is sampled high:
  - R+1: STORE.
  - R+2: `o_sample_valid` = 1, if the FIFO was empty.
- First tick after `i_enable` rises at cycle E: cycle E+`CLK_DIV`−1.
- All outputs are registered.

## Configuration

- `MOD_SYNTH_SEQ_TIMEOUT_EN` defined:
  - A WAIT watchdog counts cycles spent in WAIT.
  - On reaching `TIMEOUT` without `i_synth_ready`, the FSM goes to STORE with captured word 0 and sets `o_timeout`. This keeps the output sample rate constant.
- `MOD_SYNTH_SEQ_TIMEOUT_EN` not defined:
  - WAIT waits indefinitely.
  - `o_timeout` is tied to 0 and no watchdog logic is instantiated.

## Test plan

All scenarios use `CLK_DIV`=16, `TIMEOUT`=8, `FIFO_DEPTH`=4.

- Enable at cycle 0 with the synth model answering 3 cycles after trigger -> `o_trigger` pulses at cycles 16, 32 and 48 with `o_time` = 0, 1, 2; no flags set.
- Synth returns 0x0000_1234 with ready at cycle R -> `o_sample` = 0x0000_1234 and `o_sample_valid` = 1 at R+2; popped one cycle after `i_sample_ready` = 1.
- Hold `i_sample_ready` = 0 across 6 samples -> FIFO holds samples 0..3 and `o_overflow` = 1. Releasing `i_sample_ready` drains exactly 4 words in order, then `o_sample_valid` = 0.
- Macro defined, synth never ready -> 8 cycles into WAIT a word of 0 is pushed and `o_timeout` = 1. A later `i_clear_errors` pulse sets it back to 0.
- Macro undefined, synth ready 20 cycles after trigger -> `o_overrun` = 1 at the next tick, and the following trigger carries `o_time` = 2 (index 1 skipped).
- Assert `i_nrst` = 0 mid-WAIT with 2 words in the FIFO -> all outputs are 0 in the same cycle; after release, the first trigger has `o_time` = 0.

Source files
------------

// File: rtl/mod_synth_sequencer.sv
// Sample-rate scheduler: divides i_clk to the sample rate, triggers the synth, FIFOs its output.
// Optional WAIT watchdog enabled by defining MOD_SYNTH_SEQ_TIMEOUT_EN.
module mod_synth_sequencer #(
  parameter int unsigned CLK_DIV    = 1042,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_enable,
  input  logic               i_clear_errors,
  output logic [63:0]        o_time,
  output logic               o_trigger,
  input  logic               i_synth_ready,
  input  logic signed [31:0] i_synth_sound,
  output logic signed [31:0] o_sample,
  output logic               o_sample_valid,
  input  logic               i_sample_ready,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_overflow,
  output logic               o_timeout
);

  if (CLK_DIV < 8 || TIMEOUT + 4 >= CLK_DIV || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("mod_synth_sequencer: illegal parameter combination");
  end

  localparam int unsigned        DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam int unsigned        PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_TRIGGER, S_WAIT, S_STORE} state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [63:0]        tick_cnt_q;
  logic [63:0]        time_q;
  logic               trigger_q;
  logic               busy_q;
  logic signed [31:0] sound_q;
  logic               overrun_q;
  logic               overflow_q;
  logic               tick;

  logic signed [31:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               valid_q;
  logic               push, pop, full, push_ok;

`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
  localparam int unsigned    WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`endif

  assign tick = i_enable && (div_q == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      if (!i_enable || tick) div_q <= '0;
      else                   div_q <= div_q + 1'b1;
      if (tick) tick_cnt_q <= tick_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= S_IDLE;
      time_q    <= '0;
      trigger_q <= 1'b0;
      busy_q    <= 1'b0;
      sound_q   <= '0;
`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      trigger_q <= 1'b0;
`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
      // Later set in WAIT overrides this clear, so a coincident timeout stays flagged.
      if (i_clear_errors) timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (tick) begin
          time_q    <= tick_cnt_q;
          trigger_q <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= S_TRIGGER;
        end
        S_TRIGGER: begin
`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_synth_ready) begin
            sound_q <= i_synth_sound;
            state_q <= S_STORE;
          end
`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            sound_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_STORE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_STORE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop     = valid_q && i_sample_ready;
  assign full    = (cnt_q == FIFO_FULL);
  assign push    = (state_q == S_STORE);
  assign push_ok = push && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sound_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      overrun_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overrun_q  <= (overrun_q && !i_clear_errors) || (tick && state_q != S_IDLE);
      overflow_q <= (overflow_q && !i_clear_errors) || (push && full && !pop);
    end
  end

  assign o_time         = time_q;
  assign o_trigger      = trigger_q;
  assign o_sample       = mem_q[rd_ptr_q];
  assign o_sample_valid = valid_q;
  assign o_busy         = busy_q;
  assign o_overrun      = overrun_q;
  assign o_overflow     = overflow_q;
`ifdef MOD_SYNTH_SEQ_TIMEOUT_EN
  assign o_timeout      = timeout_q;
`else
  assign o_timeout      = 1'b0;
`endif

endmodule
